// File: rtl/fuzz_pkg.sv
// Shared types, constants and the LFSR step function for the fuzz stimulus engine.
package fuzz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } fuzz_state_e;

    localparam logic [31:0] FUZZ_LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] FUZZ_CH_SALT   = 32'h9E37_79B9;
    localparam logic [31:0] FUZZ_SIG_INIT  = 32'hFFFF_FFFF;

    // 32-bit Galois LFSR, shifting right.
    function automatic logic [31:0] lfsr32_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? FUZZ_LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/fuzz_lfsr32.sv
// One 32-bit stimulus LFSR channel with load and advance controls.
module fuzz_lfsr32
    import fuzz_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        adv,
    output logic [31:0] state
);

    // An all-zero state would lock the LFSR, so a zero load becomes 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= (load_val == '0) ? 32'h0000_0001 : load_val;
        end else if (adv) begin
            state <= lfsr32_step(state);
        end
    end

endmodule

// File: rtl/fuzz_stim_engine.sv
// Seeded multi-channel stimulus engine: holds DUT reset, drives LFSR stimulus for
// num_cycles, optionally compacts dut_out into a MISR signature (FUZZ_MISR_EN).
module fuzz_stim_engine
    import fuzz_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 8,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              seed,
    input  logic [CNT_W-1:0]         num_cycles,
    input  logic [CNT_W-1:0]         rst_hold,
    input  logic [OUT_W-1:0]         dut_out,
    output logic [NUM_CH*CH_W-1:0]   stim_o,
    output logic                     stim_valid,
    output logic                     dut_rst,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [31:0]              signature
);

    fuzz_state_e      state;
    fuzz_state_e      state_next;
    logic [31:0]      seed_q;
    logic [CNT_W-1:0] num_q;
    logic [CNT_W-1:0] hold_left;
    logic             accept;
    logic             hold_last;
    logic             run_last;
    logic             lfsr_load;
    logic             lfsr_adv;
    logic [31:0]      load_base;

    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign hold_last = (hold_left == CNT_W'(1));
    assign run_last  = (cycle_cnt == (num_q - CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (rst_hold != '0) begin
                        state_next = ST_HOLD;
                    end else if (num_cycles != '0) begin
                        state_next = ST_RUN;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_last) begin
                    state_next = (num_q != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (run_last) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        stim_valid = (state == ST_RUN);
        dut_rst    = (state == ST_IDLE) || (state == ST_HOLD);
        busy       = (state == ST_HOLD) || (state == ST_RUN);
        done       = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q    <= '0;
            num_q     <= '0;
            hold_left <= '0;
            cycle_cnt <= '0;
        end else if (accept) begin
            seed_q    <= seed;
            num_q     <= num_cycles;
            hold_left <= rst_hold;
            cycle_cnt <= '0;
        end else begin
            if (state == ST_HOLD) begin
                hold_left <= hold_left - CNT_W'(1);
            end
            if (state == ST_RUN) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
        end
    end

    // The LFSR register doubles as the stim_o flop, so seeding is deferred to
    // the edge that enters RUN and the final RUN edge does not advance: stim_o
    // then holds the last presented vector outside RUN.
    assign load_base = (state == ST_HOLD) ? seed_q : seed;
    assign lfsr_load = (state_next == ST_RUN) && (accept || (state == ST_HOLD));
    assign lfsr_adv  = (state == ST_RUN) && (state_next == ST_RUN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [31:0] ch_state;

        fuzz_lfsr32 u_lfsr (
            .clk      (clk),
            .rst      (rst),
            .load     (lfsr_load),
            .load_val (load_base ^ (FUZZ_CH_SALT * 32'(c))),
            .adv      (lfsr_adv),
            .state    (ch_state)
        );

        assign stim_o[c*CH_W +: CH_W] = ch_state[CH_W-1:0];

        if (CH_W < 32) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^ch_state[31:CH_W];
        end
    end

`ifdef FUZZ_MISR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signature <= FUZZ_SIG_INIT;
        end else if (accept) begin
            signature <= FUZZ_SIG_INIT;
        end else if (state == ST_RUN) begin
            signature <= lfsr32_step(signature) ^ 32'(dut_out);
        end
    end
`else
    logic unused_dut_out;
    assign unused_dut_out = ^dut_out;
    assign signature      = FUZZ_SIG_INIT;
`endif

endmodule

// File: tb/tb_fuzz_stim_engine.sv
// Scoreboard bench for fuzz_stim_engine (NUM_CH=2, CH_W=32); works with or without FUZZ_MISR_EN.
module tb_fuzz_stim_engine;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 32;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 16;
    localparam int SW     = NUM_CH * CH_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       seed;
    logic [CNT_W-1:0]  num_cycles;
    logic [CNT_W-1:0]  rst_hold;
    logic [OUT_W-1:0]  dut_out;
    logic [SW-1:0]     stim_o;
    logic              stim_valid;
    logic              dut_rst;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [31:0]       signature;

    logic [SW-1:0]     exp_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;

    int                hs, vs, di;
    logic [CNT_W-1:0]  cf;
    bit                to;

    fuzz_stim_engine #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W),
        .OUT_W  (OUT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .num_cycles (num_cycles),
        .rst_hold   (rst_hold),
        .dut_out    (dut_out),
        .stim_o     (stim_o),
        .stim_valid (stim_valid),
        .dut_rst    (dut_rst),
        .busy       (busy),
        .done       (done),
        .cycle_cnt  (cycle_cnt),
        .signature  (signature)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_sig(input int n, input logic [31:0] din);
        logic [31:0] s;
        s = 32'hFFFF_FFFF;
`ifdef FUZZ_MISR_EN
        for (int i = 0; i < n; i++) begin
            s = ((s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0)) ^ din;
        end
`endif
        return s;
    endfunction

    task automatic push_exp(input logic [31:0] ch1, input logic [31:0] ch0);
        exp_q.push_back({ch1, ch0});
    endtask

    // Monitor: every presented stimulus vector is matched against the queue.
    always @(negedge clk) begin
        if (stim_valid) begin
            if (exp_q.size() == 0) begin
                check("stim_unexpected", stim_o, '0);
                if (stim_o == '0) begin
                    n_fail++;
                    $display("FAIL stim_unexpected: got stim with empty queue, expected none");
                end
            end else begin
                check("stim_o", stim_o, exp_q.pop_front());
            end
        end
    end

    task automatic run_and_wait(input logic [31:0] s, input logic [CNT_W-1:0] h,
                                input logic [CNT_W-1:0] n, input logic [OUT_W-1:0] dout,
                                input int pulse_at, output int hold_seen, output int valid_seen,
                                output int done_iter, output logic [CNT_W-1:0] cnt_first,
                                output bit timed_out);
        @(negedge clk);
        seed = s; rst_hold = h; num_cycles = n; dut_out = dout; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold_seen = 0; valid_seen = 0; done_iter = -1; timed_out = 1'b1;
        cnt_first = cycle_cnt;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                timed_out = 1'b0;
                done_iter = i;
                break;
            end
            if (dut_rst && busy) hold_seen++;
            if (stim_valid) valid_seen++;
            start = (i == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; seed = '0; num_cycles = '0; rst_hold = '0; dut_out = '0;
        repeat (2) @(negedge clk);
        check("rst_stim_o", stim_o, '0);
        check("rst_stim_valid", stim_valid, 1'b0);
        check("rst_dut_rst", dut_rst, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cycle_cnt", cycle_cnt, '0);
        check("rst_signature", signature, 32'hFFFF_FFFF);
        rst = 1'b0;
        @(negedge clk);

        // Zero-length run from IDLE: straight to DONE, no stimulus.
        run_and_wait(32'h1234_5678, 0, 0, 16'h0, -1, hs, vs, di, cf, to);
        check("c_timeout", to, 1'b0);
        check("c_done_iter", di, 0);
        check("c_valid", vs, 0);
        check("c_hold", hs, 0);
        check("c_stim_zero", stim_o, '0);
        check("c_cycle_cnt", cycle_cnt, '0);
        check("c_dut_rst", dut_rst, 1'b0);
        check("c_sig", signature, 32'hFFFF_FFFF);

        // seed=1, hold 2, 4 RUN cycles, started from DONE.
        push_exp(32'h9E37_79B8, 32'h0000_0001);
        push_exp(32'h4F1B_BCDC, 32'h8020_0003);
        push_exp(32'h278D_DE6E, 32'hC030_0002);
        push_exp(32'h13C6_EF37, 32'h6018_0001);
        run_and_wait(32'h0000_0001, 2, 4, 16'h0, -1, hs, vs, di, cf, to);
        check("a_timeout", to, 1'b0);
        check("a_hold", hs, 2);
        check("a_valid", vs, 4);
        check("a_done_iter", di, 6);
        check("a_cnt_first", cf, '0);
        check("a_cycle_cnt", cycle_cnt, 4);
        check("a_stim_hold", stim_o, {32'h13C6_EF37, 32'h6018_0001});
        check("a_dut_rst", dut_rst, 1'b0);
        check("a_busy", busy, 1'b0);
        check("a_sig", signature, exp_sig(4, 32'h0));

        // seed=0: ch0 substitutes 1, ch1 loads the salt; counter cleared from DONE.
        push_exp(32'h9E37_79B9, 32'h0000_0001);
        push_exp(32'hCF3B_BCDF, 32'h8020_0003);
        push_exp(32'hE7BD_DE6C, 32'hC030_0002);
        run_and_wait(32'h0000_0000, 0, 3, 16'h00A5, -1, hs, vs, di, cf, to);
        check("b_timeout", to, 1'b0);
        check("b_hold", hs, 0);
        check("b_valid", vs, 3);
        check("b_done_iter", di, 3);
        check("b_cnt_first", cf, '0);
        check("b_cycle_cnt", cycle_cnt, 3);
        check("b_sig", signature, exp_sig(3, 32'h0000_00A5));

        // start pulsed mid-RUN must be ignored; same seed reproduces signature.
        push_exp(32'h9E37_79B8, 32'h0000_0001);
        push_exp(32'h4F1B_BCDC, 32'h8020_0003);
        push_exp(32'h278D_DE6E, 32'hC030_0002);
        push_exp(32'h13C6_EF37, 32'h6018_0001);
        run_and_wait(32'h0000_0001, 1, 4, 16'h0, 2, hs, vs, di, cf, to);
        check("d_timeout", to, 1'b0);
        check("d_hold", hs, 1);
        check("d_valid", vs, 4);
        check("d_done_iter", di, 5);
        check("d_cycle_cnt", cycle_cnt, 4);
        check("d_sig", signature, exp_sig(4, 32'h0));

        // Asynchronous reset during RUN cycle 3.
        push_exp(32'h9E37_79B8, 32'h0000_0001);
        push_exp(32'h4F1B_BCDC, 32'h8020_0003);
        push_exp(32'h278D_DE6E, 32'hC030_0002);
        @(negedge clk);
        seed = 32'h1; rst_hold = 0; num_cycles = 8; dut_out = 16'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("e_stim_o", stim_o, '0);
        check("e_stim_valid", stim_valid, 1'b0);
        check("e_dut_rst", dut_rst, 1'b1);
        check("e_busy", busy, 1'b0);
        check("e_done", done, 1'b0);
        check("e_cycle_cnt", cycle_cnt, '0);
        check("e_sig", signature, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("e_idle_busy", busy, 1'b0);
        check("e_idle_dut_rst", dut_rst, 1'b1);
        check("e_idle_done", done, 1'b0);

        // Normal run after the mid-run reset, from IDLE.
        push_exp(32'h9E37_79B8, 32'h0000_0001);
        push_exp(32'h4F1B_BCDC, 32'h8020_0003);
        push_exp(32'h278D_DE6E, 32'hC030_0002);
        push_exp(32'h13C6_EF37, 32'h6018_0001);
        run_and_wait(32'h0000_0001, 2, 4, 16'h0, -1, hs, vs, di, cf, to);
        check("f_timeout", to, 1'b0);
        check("f_hold", hs, 2);
        check("f_valid", vs, 4);
        check("f_done_iter", di, 6);
        check("f_cycle_cnt", cycle_cnt, 4);
        check("f_sig", signature, exp_sig(4, 32'h0));

        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
